cicero_spi_loader: RTL and testbench

Host-side loader for the Cicero regex coprocessor on the MKR Vidor 4000. Receives SPI mode-0 frames from the SAM D21 over MKR header pins, decodes a one-byte opcode, and streams code/data bytes with auto-incrementing addresses into the user-logic engine through a small FIFO. It also issues the engine start pulse and returns a status byte to the host. Sits directly upstream of the user module, in the internal-oscillator clock domain.

---
 rtl/cicero_spi_loader.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cicero_spi_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cicero_spi_loader.sv
// SPI mode-0 loader for the Cicero engine: opcode decode, auto-addressed byte FIFO, start pulse, status readback.
// Optional feature macro: CICERO_LOADER_CHECKSUM_EN (payload checksum returned after the status byte).
module cicero_spi_loader #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              o_wr_valid,
    output logic              o_wr_sel,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_byte,
    input  logic              i_wr_ready,
    output logic              o_start,
    input  logic [5:0]        i_status
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + 8;

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        CMD,
        WCODE,
        WDATA,
        STATUS,
        DISCARD
    } state_e;

    logic [1:0]         sck_sync_q;
    logic [1:0]         cs_sync_q;
    logic [1:0]         mosi_sync_q;
    logic               sck_prev_q;
    logic               rise_q;
    logic               fall_q;

    state_e             state_q;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         shift_q;
    logic [7:0]         tx_q;
    logic               sel_q;
    logic               push_q;
    logic [7:0]         push_byte_q;

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic               overflow_q;
    logic               start_pending_q;

`ifdef CICERO_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q;
    logic               csum_sent_q;
`endif

    logic               cs_high;
    logic               byte_done;
    logic [7:0]         rx_byte;
    logic               in_cmd;
    logic               code_open;
    logic               start_arm;
    logic               status_take;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               accept;
    logic               ovf_event;
    logic [7:0]         status_byte;

    // Edges are registered so SCK activity reaches the FSM three clocks after the pin toggles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], spi_sck};
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sck_prev_q  <= sck_sync_q[1];
            rise_q      <= sck_sync_q[1] & ~sck_prev_q;
            fall_q      <= ~sck_sync_q[1] & sck_prev_q;
        end
    end

    assign cs_high     = cs_sync_q[1];
    assign rx_byte     = {shift_q[6:0], mosi_sync_q[1]};
    assign byte_done   = (state_q != WAIT_CS) && !cs_high && rise_q && (bit_cnt_q == 3'd7);
    assign in_cmd      = byte_done && (state_q == CMD);
    assign code_open   = in_cmd && ((rx_byte == 8'h01) || (rx_byte == 8'h02));
    assign start_arm   = in_cmd && (rx_byte == 8'h03);
    assign status_take = in_cmd && (rx_byte == 8'h04);

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop         = o_wr_valid && i_wr_ready;
    assign accept      = push_q && (!fifo_full || pop);
    assign ovf_event   = push_q && fifo_full && !pop;
    assign status_byte = {overflow_q, fifo_empty, i_status};

    assign o_wr_valid  = !fifo_empty;
    assign {o_wr_sel, o_wr_addr, o_wr_byte} = mem_q[rd_ptr_q];

    // WAIT_CS keeps a frame that was already in flight at reset from being decoded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_CS;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            spi_miso    <= 1'b0;
            sel_q       <= 1'b0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
`ifdef CICERO_LOADER_CHECKSUM_EN
            csum_sent_q <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            if (cs_high) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                shift_q   <= '0;
                tx_q      <= '0;
                spi_miso  <= 1'b0;
            end else if (state_q != WAIT_CS) begin
                if (state_q == IDLE) begin
                    state_q <= CMD;
                end
                if (rise_q) begin
                    shift_q   <= rx_byte;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (fall_q && (state_q == STATUS) && (bit_cnt_q != 3'd0)) begin
                    spi_miso <= tx_q[6];
                    tx_q     <= {tx_q[6:0], 1'b0};
                end
                if (byte_done) begin
                    case (state_q)
                        CMD: begin
                            case (rx_byte)
                                8'h01: begin
                                    state_q <= WCODE;
                                    sel_q   <= 1'b0;
                                end
                                8'h02: begin
                                    state_q <= WDATA;
                                    sel_q   <= 1'b1;
                                end
                                8'h04: begin
                                    state_q  <= STATUS;
                                    tx_q     <= status_byte;
                                    spi_miso <= status_byte[7];
`ifdef CICERO_LOADER_CHECKSUM_EN
                                    csum_sent_q <= 1'b0;
`endif
                                end
                                default: state_q <= DISCARD;
                            endcase
                        end
                        WCODE, WDATA: begin
                            push_q      <= 1'b1;
                            push_byte_q <= rx_byte;
                        end
                        STATUS: begin
`ifdef CICERO_LOADER_CHECKSUM_EN
                            if (!csum_sent_q) begin
                                tx_q        <= csum_q;
                                spi_miso    <= csum_q[7];
                                csum_sent_q <= 1'b1;
                            end else begin
                                tx_q     <= '0;
                                spi_miso <= 1'b0;
                            end
`else
                            tx_q     <= '0;
                            spi_miso <= 1'b0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // A push that lands while the FIFO is full and not draining is dropped and flagged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            wr_addr_q  <= '0;
            overflow_q <= 1'b0;
`ifdef CICERO_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            count_q <= count_d;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (accept) begin
                mem_q[wr_ptr_q] <= {sel_q, wr_addr_q, push_byte_q};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (code_open) begin
                wr_addr_q <= '0;
            end else if (accept) begin
                wr_addr_q <= wr_addr_q + ADDR_W'(1);
            end
`ifdef CICERO_LOADER_CHECKSUM_EN
            if (code_open) begin
                csum_q <= '0;
            end else if (accept) begin
                csum_q <= csum_q + push_byte_q;
            end
`endif
            if (ovf_event) begin
                overflow_q <= 1'b1;
            end else if (status_take) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // The start pulse waits until every queued byte has been taken by the engine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_start         <= 1'b0;
            start_pending_q <= 1'b0;
        end else begin
            o_start <= 1'b0;
            if ((start_arm || start_pending_q) && fifo_empty) begin
                o_start         <= 1'b1;
                start_pending_q <= 1'b0;
            end else if (start_arm) begin
                start_pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cicero_spi_loader.sv
// Self-checking bench for cicero_spi_loader: randomized SPI frames checked against a queue-based write/status model.
module tb_cicero_spi_loader;

    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 8;
    localparam int HALF       = 100;

    logic              clk;
    logic              reset_n;
    logic              spi_sck;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              o_wr_valid;
    logic              o_wr_sel;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0]        o_wr_byte;
    logic              i_wr_ready;
    logic              o_start;
    logic [5:0]        i_status;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+8:0] obs_q [$];
    logic [ADDR_W+8:0] exp_q [$];
    logic [7:0]        tx_buf [32];
    logic [7:0]        rx_buf [32];
    int                cyc = 0;
    int                last_pop_cyc = 0;
    int                start_cnt = 0;
    int                start_cyc = 0;
    int                miso_high_cnt = 0;

    cicero_spi_loader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .o_wr_valid (o_wr_valid),
        .o_wr_sel   (o_wr_sel),
        .o_wr_addr  (o_wr_addr),
        .o_wr_byte  (o_wr_byte),
        .i_wr_ready (i_wr_ready),
        .o_start    (o_start),
        .i_status   (i_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe the write port, start pulses and MISO activity away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && o_wr_valid && i_wr_ready) begin
            obs_q.push_back({o_wr_sel, o_wr_addr, o_wr_byte});
            last_pop_cyc <= cyc;
        end
        if (o_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (spi_miso) begin
            miso_high_cnt <= miso_high_cnt + 1;
        end
    end

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 i_wr_ready = v;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #(HALF);
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            #(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input int nbytes, input int extra_bits);
        logic [7:0] r;
        spi_cs_n = 1'b0;
        #(HALF);
        for (int b = 0; b < nbytes; b++) begin
            spi_byte(tx_buf[b], r);
            rx_buf[b] = r;
        end
        for (int k = 0; k < extra_bits; k++) begin
            spi_mosi = 1'b1;
            #(HALF);
            spi_sck = 1'b1;
            #(HALF);
            spi_sck = 1'b0;
        end
        #(HALF);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #(4 * HALF);
    endtask

    task automatic compare_writes(input string name);
        logic [ADDR_W+8:0] got;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL %s_count: got %0d writes, expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < obs_q.size()) ? obs_q[i] : 'x;
            n_checks++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL %s_entry%0d: got sel=%b addr=%0d byte=%h, expected sel=%b addr=%0d byte=%h",
                         name, i, got[ADDR_W+8], got[ADDR_W+7:8], got[7:0],
                         exp_q[i][ADDR_W+8], exp_q[i][ADDR_W+7:8], exp_q[i][7:0]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        reset_n    = 1'b0;
        spi_cs_n   = 1'b1;
        spi_sck    = 1'b0;
        spi_mosi   = 1'b0;
        i_wr_ready = 1'b0;
        i_status   = 6'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 6;
        if (spi_miso !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_miso: got %b expected 0", spi_miso); end
        if (o_wr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", o_wr_valid); end
        if (o_wr_sel !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_sel: got %b expected 0", o_wr_sel); end
        if (o_wr_addr !== '0)    begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 0", o_wr_addr); end
        if (o_wr_byte !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_byte: got %h expected 00", o_wr_byte); end
        if (o_start !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_start: got %b expected 0", o_start); end
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_wcode;
        int len;
        logic sel;
        set_ready(1'b1);
        tx_buf[0] = 8'h01; tx_buf[1] = 8'hAA; tx_buf[2] = 8'h55;
        spi_frame(3, 0);
        exp_q.push_back({1'b0, 10'd0, 8'hAA});
        exp_q.push_back({1'b0, 10'd1, 8'h55});
        compare_writes("wcode_fixed");
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(1, 6);
            sel = 1'($urandom_range(0, 1));
            tx_buf[0] = sel ? 8'h02 : 8'h01;
            for (int i = 1; i <= len; i++) begin
                tx_buf[i] = 8'($urandom);
                exp_q.push_back({sel, ADDR_W'(i - 1), tx_buf[i]});
            end
            spi_frame(len + 1, 0);
            compare_writes("wr_random");
        end
        n_checks++;
        if (start_cnt !== 0) begin
            n_fail++;
            $display("[TB] FAIL wcode_no_start: got %0d start pulses, expected 0", start_cnt);
        end
    endtask

    task automatic test_overflow;
        int n;
        int accepted;
        logic [7:0] sum;
        logic [7:0] st;
        logic [7:0] exp_b;
        n = FIFO_DEPTH + 2;
        accepted = FIFO_DEPTH;
        sum = 8'h00;
        st = {2'b00, 6'($urandom)};
        i_status = st[5:0];
        set_ready(1'b0);
        tx_buf[0] = 8'h02;
        for (int i = 1; i <= n; i++) begin
            tx_buf[i] = 8'($urandom);
            if (i <= accepted) begin
                exp_q.push_back({1'b1, ADDR_W'(i - 1), tx_buf[i]});
                sum = sum + tx_buf[i];
            end
        end
        spi_frame(n + 1, 0);
        tx_buf[0] = 8'h04; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        spi_frame(4, 0);
        exp_b = {1'b1, 1'b0, st[5:0]};
        n_checks++;
        if (rx_buf[1] !== exp_b) begin n_fail++; $display("[TB] FAIL ovf_status1: got %h expected %h", rx_buf[1], exp_b); end
`ifdef CICERO_LOADER_CHECKSUM_EN
        exp_b = sum;
`else
        exp_b = 8'h00;
`endif
        n_checks += 2;
        if (rx_buf[2] !== exp_b) begin n_fail++; $display("[TB] FAIL ovf_second_byte: got %h expected %h", rx_buf[2], exp_b); end
        if (rx_buf[3] !== 8'h00) begin n_fail++; $display("[TB] FAIL ovf_trailing_byte: got %h expected 00", rx_buf[3]); end
        spi_frame(2, 0);
        exp_b = {1'b0, 1'b0, st[5:0]};
        n_checks++;
        if (rx_buf[1] !== exp_b) begin n_fail++; $display("[TB] FAIL ovf_status2: got %h expected %h", rx_buf[1], exp_b); end
        n_checks++;
        if (obs_q.size() !== 0) begin n_fail++; $display("[TB] FAIL ovf_held: got %0d writes while not ready, expected 0", obs_q.size()); end
        set_ready(1'b1);
        repeat (FIFO_DEPTH + 10) @(posedge clk);
        compare_writes("ovf_drain");
    endtask

    task automatic test_status;
        logic [7:0] exp_b;
        logic [7:0] sum;
        i_status = 6'h2A;
        tx_buf[0] = 8'h04; tx_buf[1] = 8'h00;
        spi_frame(2, 0);
        n_checks++;
        if (rx_buf[1] !== 8'h6A) begin n_fail++; $display("[TB] FAIL status_2a: got %h expected 6a", rx_buf[1]); end
        for (int r = 0; r < 2; r++) begin
            i_status = 6'($urandom);
            spi_frame(2, 0);
            exp_b = {2'b01, i_status};
            n_checks++;
            if (rx_buf[1] !== exp_b) begin n_fail++; $display("[TB] FAIL status_rand: got %h expected %h", rx_buf[1], exp_b); end
        end
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h10; tx_buf[2] = 8'h20; tx_buf[3] = 8'hF5;
        spi_frame(4, 0);
        obs_q.delete();
        sum = 8'h10 + 8'h20 + 8'hF5;
        tx_buf[0] = 8'h04; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
        spi_frame(4, 0);
`ifdef CICERO_LOADER_CHECKSUM_EN
        exp_b = sum;
`else
        exp_b = 8'h00;
`endif
        n_checks += 3;
        if (rx_buf[0] !== 8'h00) begin n_fail++; $display("[TB] FAIL status_opcode_miso: got %h expected 00", rx_buf[0]); end
        if (rx_buf[2] !== exp_b) begin n_fail++; $display("[TB] FAIL status_checksum: got %h expected %h", rx_buf[2], exp_b); end
        if (rx_buf[3] !== 8'h00) begin n_fail++; $display("[TB] FAIL status_tail: got %h expected 00", rx_buf[3]); end
    endtask

    task automatic test_start;
        int base;
        int gap;
        set_ready(1'b0);
        tx_buf[0] = 8'h01;
        for (int i = 1; i <= 3; i++) begin
            tx_buf[i] = 8'($urandom);
            exp_q.push_back({1'b0, ADDR_W'(i - 1), tx_buf[i]});
        end
        spi_frame(4, 0);
        base = start_cnt;
        tx_buf[0] = 8'h03;
        spi_frame(1, 0);
        n_checks++;
        if (start_cnt !== base) begin n_fail++; $display("[TB] FAIL start_early: got %0d pulses, expected %0d", start_cnt, base); end
        set_ready(1'b1);
        repeat (30) @(posedge clk);
        gap = start_cyc - last_pop_cyc;
        n_checks += 2;
        if (start_cnt !== base + 1) begin n_fail++; $display("[TB] FAIL start_once: got %0d pulses, expected %0d", start_cnt, base + 1); end
        if (gap < 1 || gap > 2) begin n_fail++; $display("[TB] FAIL start_timing: got gap %0d cycles after last pop, expected 1..2", gap); end
        compare_writes("start_drain");
        base = start_cnt;
        tx_buf[0] = 8'h03;
        spi_frame(1, 0);
        n_checks++;
        if (start_cnt !== base + 1) begin n_fail++; $display("[TB] FAIL start_empty: got %0d pulses, expected %0d", start_cnt, base + 1); end
        set_ready(1'b0);
        tx_buf[0] = 8'h02; tx_buf[1] = 8'($urandom);
        exp_q.push_back({1'b1, 10'd0, tx_buf[1]});
        spi_frame(2, 0);
        base = start_cnt;
        tx_buf[0] = 8'h03;
        spi_frame(1, 0);
        spi_frame(1, 0);
        set_ready(1'b1);
        repeat (30) @(posedge clk);
        n_checks++;
        if (start_cnt !== base + 1) begin n_fail++; $display("[TB] FAIL start_double: got %0d pulses, expected %0d", start_cnt, base + 1); end
        compare_writes("start_double_drain");
    endtask

    task automatic test_abort;
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h3C;
        exp_q.push_back({1'b0, 10'd0, 8'h3C});
        spi_frame(2, 5);
        compare_writes("abort_partial");
        tx_buf[0] = 8'h02; tx_buf[1] = 8'h11;
        exp_q.push_back({1'b1, 10'd0, 8'h11});
        spi_frame(2, 0);
        compare_writes("abort_next_frame");
        miso_high_cnt = 0;
        tx_buf[0] = 8'h7F; tx_buf[1] = 8'($urandom); tx_buf[2] = 8'($urandom);
        spi_frame(3, 0);
        compare_writes("bad_opcode");
        n_checks += 2;
        if (miso_high_cnt !== 0) begin n_fail++; $display("[TB] FAIL bad_opcode_miso: got %0d high cycles, expected 0", miso_high_cnt); end
        if (rx_buf[1] !== 8'h00) begin n_fail++; $display("[TB] FAIL bad_opcode_rx: got %h expected 00", rx_buf[1]); end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] r;
        spi_cs_n = 1'b0;
        #(HALF);
        spi_byte(8'h01, r);
        spi_byte(8'h77, r);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 3;
        if (o_wr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_valid: got %b expected 0", o_wr_valid); end
        if (o_wr_addr !== '0)    begin n_fail++; $display("[TB] FAIL midreset_addr: got %h expected 0", o_wr_addr); end
        if (spi_miso !== 1'b0)   begin n_fail++; $display("[TB] FAIL midreset_miso: got %b expected 0", spi_miso); end
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        obs_q.delete();
        spi_byte(8'h01, r);
        spi_byte(8'h5A, r);
        spi_byte(8'hC3, r);
        #(HALF);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #(4 * HALF);
        compare_writes("midreset_ignored");
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h99;
        exp_q.push_back({1'b0, 10'd0, 8'h99});
        spi_frame(2, 0);
        compare_writes("midreset_new_frame");
    endtask

    initial begin
        $display("[TB] cicero_spi_loader bench start");
        test_reset();
        test_wcode();
        test_overflow();
        test_status();
        test_start();
        test_abort();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
